life_run_ctrl: RTL and testbench
================================

Name: life_run_ctrl

Overview:
Sequencer that owns a life_array_4x4 instance on behalf of a host. It accepts a 16-bit seed pattern and a generation budget, clears the array, then writes all 16 cells through the row/col/val/write_enb port. It then steps the array one generation at a time and classifies the evolution as extinct, still-life, period-2 oscillator, or budget exhausted. It sits between host/test logic and the array; the array's own ports are driven only by this block.

Parameters:
SETTLE_CYCLES, 1, idle cycles after each run pulse or last write before alive is sampled (1..15)
GEN_W, 8, width of generation budget and counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
start  input  1  request to load and run; accepted only when busy=0
pattern  input  16  seed; bit index 4*col+row (bit0 = row0,col0; bit4 = row0,col1)
gen_count  input  GEN_W  maximum generations to run
abort  input  1  cancel the current run and return to IDLE
busy  output  1  high from the cycle after accept until DONE/abort completes
done  output  1  one-cycle pulse when a run completes
result  output  2  00 LIMIT, 01 EXTINCT, 10 STILL, 11 PERIOD2
gens_done  output  GEN_W  generations executed in the last run
final_alive  output  16  array state at completion
arr_reset  output  1  active-high clear to array
arr_row  output  2  array row select
arr_col  output  2  array column select
arr_val  output  1  array write data
arr_write_enb  output  1  array write strobe
arr_run  output  1  array generation enable
arr_alive  input  16  array state

Behaviour:
- All outputs are registered. Reset values: busy=0, done=0, result=00, gens_done=0, final_alive=0, arr_reset=1 (clears the array on the next edge), arr_row=0, arr_col=0, arr_val=0, arr_write_enb=0, arr_run=0. The FSM resets to IDLE.
- FSM states: IDLE -> CLEAR -> WRITE -> SETTLE -> STEP -> WAIT -> CHECK -> (STEP | DONE) -> IDLE.
- IDLE: arr_reset=0. On start=1, capture pattern and gen_count, clear gens_done and the history-valid flags, and go to CLEAR. start while busy=1 is ignored.
- CLEAR: arr_reset=1 for exactly 1 cycle.
- WRITE: 16 cycles, cell index k=0..15. Drive arr_row=k[1:0], arr_col=k[3:2], arr_val=pattern[k], arr_write_enb=1. Zeros are written explicitly.
- SETTLE/WAIT: arr_write_enb=0 and arr_run=0 for SETTLE_CYCLES cycles.
- Timing with SETTLE_CYCLES=1: the first arr_run pulse occurs on cycle 18 after the accept edge.
- If gen_count==0, skip SETTLE and STEP. Go directly to DONE with result=LIMIT, gens_done=0, final_alive=arr_alive sampled after one settle.
- STEP: arr_run=1 for exactly 1 cycle, then gens_done increments.
- CHECK (1 cycle) compares arr_alive against prev (state before this generation) and prev2 (state two generations back).
- Classification priority when conditions coincide: EXTINCT (alive==0) > STILL (alive==prev) > PERIOD2 (alive==prev2, only when gens_done>=2) > LIMIT (gens_done==gen_count) > continue.
- On continue: prev2<=prev, prev<=alive, go to STEP.
- prev is loaded with the pattern before the first step.
- DONE: latch final_alive and result, pulse done for 1 cycle, drop busy on the same cycle, return to IDLE. result, gens_done and final_alive hold until the next accepted start.
- abort: when busy, abort forces IDLE on the next edge with arr_run=0 and arr_write_enb=0. No done pulse; result, gens_done and final_alive are unchanged. abort in IDLE has no effect. If abort and start are asserted together in IDLE, start wins.
- Reset mid-operation returns everything to reset values; the array is cleared via arr_reset=1.
- gens_done saturates at 2^GEN_W-1; it cannot wrap because LIMIT stops the run first.

Test Plan:
- Lone cell: pattern=16'h0001, gen_count=10 -> done, result=01, gens_done=1, final_alive=0. Observe 16 writes, index k at row=k%4, col=k/4.
- Block: pattern=16'h0660, gen_count=10 -> result=10, gens_done=1, final_alive=16'h0660.
- Blinker: pattern=16'h0222, gen_count=10 -> result=11, gens_done=2, final_alive=16'h0222. Beacon 16'hCC33 -> result=11, gens_done=2, final_alive=16'hCC33. Toad 16'h6186 -> result=11, gens_done=2.
- Budget: blinker with gen_count=1 -> result=00, gens_done=1, final_alive=16'h0070. Repeat with gen_count=0 -> result=00, gens_done=0, final_alive=16'h0222, no arr_run pulse.
- Abort/start-while-busy: start the beehive 16'h6996; pulse start again during WRITE -> ignored. Assert abort during STEP -> busy=0 next cycle, no done, previous result retained.
- Mid-run reset: reset=0 during WAIT -> all outputs at reset values and arr_reset=1. A new start afterwards completes normally.

Source files
------------

// File: rtl/life_run_ctrl.sv
// life_run_ctrl: sequences a 4x4 Life array for a host. Clears the array,
// writes a 16-cell seed, steps it one generation at a time and classifies
// the evolution as extinct, still life, period-2 oscillator or budget limit.
module life_run_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int GEN_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      pattern,
  input  logic [GEN_W-1:0] gen_count,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [GEN_W-1:0] gens_done,
  output logic [15:0]      final_alive,
  output logic             arr_reset,
  output logic [1:0]       arr_row,
  output logic [1:0]       arr_col,
  output logic             arr_val,
  output logic             arr_write_enb,
  output logic             arr_run,
  input  logic [15:0]      arr_alive
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_WRITE  = 3'd2,
    S_SETTLE = 3'd3,
    S_STEP   = 3'd4,
    S_WAIT   = 3'd5,
    S_CHECK  = 3'd6,
    S_DONE   = 3'd7
  } state_t;

  localparam logic [1:0]       RES_LIMIT   = 2'b00;
  localparam logic [1:0]       RES_EXTINCT = 2'b01;
  localparam logic [1:0]       RES_STILL   = 2'b10;
  localparam logic [1:0]       RES_PERIOD2 = 2'b11;
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [GEN_W-1:0] GEN_MAX     = {GEN_W{1'b1}};
  localparam logic [GEN_W-1:0] GEN_ZERO    = {GEN_W{1'b0}};
  localparam logic [GEN_W-1:0] GEN_ONE     = GEN_W'(1);
  localparam logic [GEN_W-1:0] GEN_TWO     = GEN_W'(2);

  state_t           state_q, state_d;
  logic [15:0]      pat_q, pat_d;
  logic [GEN_W-1:0] budget_q, budget_d;
  logic [3:0]       idx_q, idx_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [15:0]      prev_q, prev_d;
  logic [15:0]      prev2_q, prev2_d;
  logic [GEN_W-1:0] gens_q, gens_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       result_q, result_d;
  logic [15:0]      final_q, final_d;
  logic             arr_reset_q, arr_reset_d;
  logic [1:0]       row_q, row_d;
  logic [1:0]       col_q, col_d;
  logic             val_q, val_d;
  logic             we_q, we_d;
  logic             run_q, run_d;

  // Next-state, bookkeeping and next registered array-port values.
  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    budget_d    = budget_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev2_d     = prev2_q;
    gens_d      = gens_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    final_d     = final_q;
    arr_reset_d = 1'b0;
    row_d       = 2'b00;
    col_d       = 2'b00;
    val_d       = 1'b0;
    we_d        = 1'b0;
    run_d       = 1'b0;

    case (state_q)
      // DONE behaves like IDLE for a new start since busy is already low.
      S_IDLE, S_DONE: begin
        if (start) begin
          pat_d    = pattern;
          budget_d = gen_count;
          gens_d   = GEN_ZERO;
          prev_d   = pattern;
          prev2_d  = 16'h0000;
          busy_d   = 1'b1;
          state_d  = S_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        idx_d   = 4'd0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (idx_q == 4'd15) begin
          cnt_d   = 4'd0;
          state_d = S_SETTLE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          if (budget_q == GEN_ZERO) begin
            result_d = RES_LIMIT;
            final_d  = arr_alive;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = S_DONE;
          end else begin
            state_d = S_STEP;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_STEP: begin
        cnt_d   = 4'd0;
        gens_d  = (gens_q == GEN_MAX) ? gens_q : gens_q + GEN_ONE;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // Earlier tests take priority when several conditions hold at once.
        if (arr_alive == 16'h0000) begin
          result_d = RES_EXTINCT;
          state_d  = S_DONE;
        end else if (arr_alive == prev_q) begin
          result_d = RES_STILL;
          state_d  = S_DONE;
        end else if ((gens_q >= GEN_TWO) && (arr_alive == prev2_q)) begin
          result_d = RES_PERIOD2;
          state_d  = S_DONE;
        end else if (gens_q == budget_q) begin
          result_d = RES_LIMIT;
          state_d  = S_DONE;
        end else begin
          prev2_d = prev_q;
          prev_d  = arr_alive;
          state_d = S_STEP;
        end
        if (state_d == S_DONE) begin
          final_d = arr_alive;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          final_d = final_q;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase

    // Abort only matters while a run is in flight; results keep their values.
    if (abort && busy_q) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      gens_d   = gens_q;
      result_d = result_q;
      final_d  = final_q;
    end else begin
      busy_d = busy_d;
    end

    // Array port values belong to the state being entered.
    case (state_d)
      S_CLEAR: begin
        arr_reset_d = 1'b1;
      end
      S_WRITE: begin
        row_d = idx_d[1:0];
        col_d = idx_d[3:2];
        val_d = pat_d[idx_d];
        we_d  = 1'b1;
      end
      S_STEP: begin
        run_d = 1'b1;
      end
      default: begin
        arr_reset_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pat_q       <= 16'h0000;
      budget_q    <= GEN_ZERO;
      idx_q       <= 4'd0;
      cnt_q       <= 4'd0;
      prev_q      <= 16'h0000;
      prev2_q     <= 16'h0000;
      gens_q      <= GEN_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= RES_LIMIT;
      final_q     <= 16'h0000;
      arr_reset_q <= 1'b1;
      row_q       <= 2'b00;
      col_q       <= 2'b00;
      val_q       <= 1'b0;
      we_q        <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      budget_q    <= budget_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      prev2_q     <= prev2_d;
      gens_q      <= gens_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      final_q     <= final_d;
      arr_reset_q <= arr_reset_d;
      row_q       <= row_d;
      col_q       <= col_d;
      val_q       <= val_d;
      we_q        <= we_d;
      run_q       <= run_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign gens_done     = gens_q;
  assign final_alive   = final_q;
  assign arr_reset     = arr_reset_q;
  assign arr_row       = row_q;
  assign arr_col       = col_q;
  assign arr_val       = val_q;
  assign arr_write_enb = we_q;
  assign arr_run       = run_q;

endmodule

// File: tb/tb_life_run_ctrl.sv
// Bench for life_run_ctrl: a behavioural 4x4 Life array answers the DUT's
// array port, a reference model predicts each run's outcome into a queue,
// and a negedge monitor pops and compares on every done pulse.
module tb_life_run_ctrl;

  typedef struct packed {
    logic [1:0]  res;
    logic [7:0]  gens;
    logic [15:0] fin;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [15:0] pattern;
  logic [7:0]  gen_count;
  logic        busy, done;
  logic [1:0]  result;
  logic [7:0]  gens_done;
  logic [15:0] final_alive;
  logic        arr_reset, arr_val, arr_write_enb, arr_run;
  logic [1:0]  arr_row, arr_col;
  logic [15:0] arr_alive = 16'h0000;

  int   passed = 0;
  int   total  = 0;
  int   done_cnt = 0;
  int   since = 0, wr_cnt = 0, run_cnt = 0;
  bit   busy_prev = 1'b0, first_run_pend = 1'b0;
  logic [15:0] cur_pat = 16'h0000;
  exp_t exp_q[$];
  exp_t last_exp = '0;

  always #5 clk = ~clk;

  life_run_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .gen_count(gen_count), .abort(abort), .busy(busy), .done(done),
    .result(result), .gens_done(gens_done), .final_alive(final_alive),
    .arr_reset(arr_reset), .arr_row(arr_row), .arr_col(arr_col),
    .arr_val(arr_val), .arr_write_enb(arr_write_enb), .arr_run(arr_run),
    .arr_alive(arr_alive)
  );

  // One Life generation on a 4x4 board with dead cells outside the edge.
  function automatic logic [15:0] life_next(input logic [15:0] s);
    logic [15:0] n;
    int nb, rr, cc;
    n = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        nb = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            rr = r + dr;
            cc = c + dc;
            if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 4 && cc >= 0 && cc < 4)
              if (s[4*cc+rr]) nb++;
          end
        end
        if (s[4*c+r]) n[4*c+r] = (nb == 2 || nb == 3);
        else          n[4*c+r] = (nb == 3);
      end
    end
    return n;
  endfunction

  // Predict a whole run from the history of generations.
  function automatic exp_t ref_model(input logic [15:0] pat, input int gc);
    logic [15:0] hist[$];
    logic [15:0] nxt;
    exp_t e;
    e.res = 2'b00; e.gens = 8'd0; e.fin = pat;
    hist.push_back(pat);
    for (int g = 1; g <= gc; g++) begin
      nxt = life_next(hist[g-1]);
      e.gens = 8'(g);
      e.fin  = nxt;
      if (nxt == 16'h0000) begin e.res = 2'b01; return e; end
      if (nxt == hist[g-1]) begin e.res = 2'b10; return e; end
      if (g >= 2 && nxt == hist[g-2]) begin e.res = 2'b11; return e; end
      hist.push_back(nxt);
    end
    e.res = 2'b00;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural array: clear, then cell write, then generation step.
  always @(posedge clk) begin
    if (arr_reset) arr_alive <= 16'h0000;
    else if (arr_write_enb) arr_alive[{arr_col, arr_row}] <= arr_val;
    else if (arr_run) arr_alive <= life_next(arr_alive);
  end

  // Monitor: write order, first run timing, and scoreboard on done.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (busy && !busy_prev) begin
        since = 0; wr_cnt = 0; run_cnt = 0; first_run_pend = 1'b1;
      end else begin
        since++;
      end
      if (arr_write_enb) begin
        chk("write_cell", {26'd0, arr_row, arr_col, arr_val},
            {26'd0, wr_cnt[1:0], wr_cnt[3:2], cur_pat[wr_cnt[3:0]]});
        wr_cnt++;
      end
      if (arr_run) begin
        run_cnt++;
        if (first_run_pend) begin
          chk("first_run_cycle", since, 18);
          first_run_pend = 1'b0;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_has_expect", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          last_exp = e;
          chk("result", {30'd0, result}, {30'd0, e.res});
          chk("gens_done", {24'd0, gens_done}, {24'd0, e.gens});
          chk("final_alive", {16'd0, final_alive}, {16'd0, e.fin});
          chk("busy_at_done", {31'd0, busy}, 32'd0);
          chk("write_count", wr_cnt, 16);
          chk("run_pulses", run_cnt, {24'd0, e.gens});
        end
      end
    end
    busy_prev = busy;
  end

  task automatic do_start(input logic [15:0] p, input logic [7:0] g, input bit expect_done);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin @(negedge clk); n++; end
    start = 1'b1; pattern = p; gen_count = g; cur_pat = p;
    if (expect_done) exp_q.push_back(ref_model(p, int'(g)));
    @(posedge clk);
    #1 start = 1'b0;
    pattern = 16'($urandom);
    gen_count = 8'($urandom);
  endtask

  task automatic run_wait(input logic [15:0] p, input logic [7:0] g);
    int target, n;
    target = done_cnt + 1;
    do_start(p, g, 1'b1);
    n = 0;
    while (done_cnt < target && n < 3000) begin @(negedge clk); n++; end
    chk("done_seen", {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic wait_run_pulse();
    int n;
    n = 0;
    while (!arr_run && n < 200) begin @(negedge clk); n++; end
    chk("run_pulse_seen", {31'd0, arr_run}, 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arr_reset"}, {31'd0, arr_reset}, 32'd1);
    chk({tag, "_outs"}, {busy, done, result, gens_done, final_alive, arr_row, arr_col},
        32'd0);
    chk({tag, "_strobes"}, {29'd0, arr_val, arr_write_enb, arr_run}, 32'd0);
  endtask

  initial begin
    logic [15:0] dir_pat [7] = '{16'h0001, 16'h0660, 16'h0222, 16'hCC33,
                                  16'h6186, 16'h0222, 16'h0222};
    logic [7:0]  dir_gc  [7] = '{8'd10, 8'd10, 8'd10, 8'd10, 8'd10, 8'd1, 8'd0};
    int n;

    reset = 1'b0; start = 1'b0; abort = 1'b0; pattern = 16'h0000; gen_count = 8'd0;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b1;
    @(negedge clk);
    chk("idle_arr_reset", {31'd0, arr_reset}, 32'd0);

    for (int i = 0; i < 7; i++) run_wait(dir_pat[i], dir_gc[i]);

    for (int i = 0; i < 20; i++) run_wait(16'($urandom), 8'($urandom_range(0, 12)));

    // Ignored start during WRITE, then abort during the first STEP.
    do_start(16'h6996, 8'd10, 1'b0);
    n = 0;
    while (!arr_write_enb && n < 50) begin @(negedge clk); n++; end
    start = 1'b1; pattern = 16'hFFFF; gen_count = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    wait_run_pulse();
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_strobes", {30'd0, arr_run, arr_write_enb}, 32'd0);
    chk("abort_result", {30'd0, result}, {30'd0, last_exp.res});
    chk("abort_final", {16'd0, final_alive}, {16'd0, last_exp.fin});
    chk("abort_gens", {24'd0, gens_done}, 32'd0);
    repeat (40) @(negedge clk);

    // Reset while waiting after a step, then a normal run.
    do_start(16'h0660, 8'd10, 1'b1);
    @(negedge clk);
    wait_run_pulse();
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset_vals("midrst");
    reset = 1'b1;
    last_exp = '0;
    repeat (3) @(negedge clk);
    run_wait(16'h0222, 8'd10);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
